// File: rtl/rtc_bus_driver_if.sv
// Request/chip-side bundle for the RTC parallel bus driver.
// master: the driver itself; slave: the request source plus the pad/chip side.
interface rtc_bus_driver_if;
  logic       start;
  logic       RD_WR;
  logic [7:0] dir_out;
  logic [7:0] dato;
  logic [7:0] dato_rtc;
  logic       busy;
  logic       done;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;

  modport master (
    input  start, RD_WR, dir_out, dato, ad_in,
    output dato_rtc, busy, done, cs_n, rd_n, wr_n, a_d, ad_out, ad_oe
  );

  modport slave (
    output start, RD_WR, dir_out, dato, ad_in,
    input  dato_rtc, busy, done, cs_n, rd_n, wr_n, a_d, ad_out, ad_oe
  );
endinterface

// File: rtl/rtc_bus_driver.sv
// Multiplexed address/data strobe sequencer for a parallel RTC chip.
// Every chip-side output is registered from the next state, so strobes never glitch.
module rtc_bus_driver #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 10,
  parameter int T_GAP   = 5
) (
  input  logic             clk,
  input  logic             reset,
  rtc_bus_driver_if.master bus
);
  localparam int TMAX = (T_PULSE > T_SETUP) ? ((T_PULSE > T_GAP) ? T_PULSE : T_GAP)
                                            : ((T_SETUP > T_GAP) ? T_SETUP : T_GAP);
  localparam int CW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE, A_SETUP, A_STRB, A_HOLD, GAP, D_SETUP, D_STRB, D_HOLD
  } state_t;

  state_t          state, nxt;
  logic [CW-1:0]   cnt, nxt_cnt;
  logic            rd_q;
  logic [7:0]      data_q;
  logic            accept, expire, capture;
  logic            n_in_a, n_in_d;
  logic            n_cs_n, n_rd_n, n_wr_n, n_a_d, n_oe, n_busy, n_done;
  logic [7:0]      n_ad_out;

  assign expire  = (cnt == '0);
  assign accept  = (state == IDLE) && bus.start;
  assign capture = (state == D_STRB) && expire && rd_q;

  always_comb begin
    nxt     = state;
    nxt_cnt = cnt;
    case (state)
      IDLE:    if (bus.start) begin nxt = A_SETUP; nxt_cnt = CW'(T_SETUP - 1); end
      A_SETUP: if (expire) begin nxt = A_STRB; nxt_cnt = CW'(T_PULSE - 1); end
               else nxt_cnt = cnt - 1'b1;
      A_STRB:  if (expire) nxt = A_HOLD;
               else nxt_cnt = cnt - 1'b1;
      A_HOLD:  begin nxt = GAP; nxt_cnt = CW'(T_GAP - 1); end
      GAP:     if (expire) begin nxt = D_SETUP; nxt_cnt = CW'(T_SETUP - 1); end
               else nxt_cnt = cnt - 1'b1;
      D_SETUP: if (expire) begin nxt = D_STRB; nxt_cnt = CW'(T_PULSE - 1); end
               else nxt_cnt = cnt - 1'b1;
      D_STRB:  if (expire) nxt = D_HOLD;
               else nxt_cnt = cnt - 1'b1;
      D_HOLD:  nxt = IDLE;
      default: nxt = IDLE;
    endcase

    // Outputs are decoded from the state being entered, then registered.
    // The address phase always strobes WR, even for reads.
    n_in_a   = (nxt == A_SETUP) || (nxt == A_STRB) || (nxt == A_HOLD);
    n_in_d   = (nxt == D_SETUP) || (nxt == D_STRB) || (nxt == D_HOLD);
    n_cs_n   = !(n_in_a || n_in_d);
    n_a_d    = !n_in_a;
    n_wr_n   = !((nxt == A_STRB) || ((nxt == D_STRB) && !rd_q));
    n_rd_n   = !((nxt == D_STRB) && rd_q);
    n_oe     = n_in_a || (n_in_d && !rd_q);
    n_busy   = (nxt != IDLE);
    n_done   = (state == D_HOLD);
    n_ad_out = bus.ad_out;
    if (accept)
      n_ad_out = bus.dir_out;
    else if ((state == GAP) && (nxt == D_SETUP) && !rd_q)
      n_ad_out = data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rd_q         <= 1'b0;
      data_q       <= '0;
      bus.cs_n     <= 1'b1;
      bus.rd_n     <= 1'b1;
      bus.wr_n     <= 1'b1;
      bus.a_d      <= 1'b1;
      bus.ad_oe    <= 1'b0;
      bus.ad_out   <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.dato_rtc <= '0;
    end else begin
      state      <= nxt;
      cnt        <= nxt_cnt;
      if (accept) begin
        rd_q   <= bus.RD_WR;
        data_q <= bus.dato;
      end
      bus.cs_n   <= n_cs_n;
      bus.rd_n   <= n_rd_n;
      bus.wr_n   <= n_wr_n;
      bus.a_d    <= n_a_d;
      bus.ad_oe  <= n_oe;
      bus.ad_out <= n_ad_out;
      bus.busy   <= n_busy;
      bus.done   <= n_done;
      if (capture) bus.dato_rtc <= bus.ad_in;
    end
  end
endmodule

// File: tb/tb_rtc_bus_driver.sv
// Directed bench for rtc_bus_driver: a phase-offset model checked every cycle,
// plus literal expectations for each scenario.
module tb_rtc_bus_driver;
  localparam int TS = 2, TP = 10, TG = 5;
  localparam int BL     = 2*TS + 2*TP + TG + 2;
  localparam int A_STB0 = TS + 1;
  localparam int A_STB1 = TS + TP;
  localparam int A_HLD  = TS + TP + 1;
  localparam int G1     = A_HLD + TG;
  localparam int D_STB0 = G1 + TS + 1;
  localparam int D_STB1 = G1 + TS + TP;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rd_byte = 8'h00;
  always #5 clk = ~clk;

  rtc_bus_driver_if bus();
  assign bus.ad_in = bus.rd_n ? 8'h00 : rd_byte;

  rtc_bus_driver #(.T_SETUP(TS), .T_PULSE(TP), .T_GAP(TG)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int errors = 0, checks = 0;

  // model: p = edges since acceptance (1 = first busy cycle, BL+1 = done cycle)
  bit         act = 1'b0;
  int         p = 0;
  bit         m_rd = 1'b0;
  logic [7:0] m_addr = 8'h00, m_data = 8'h00, m_ad_out = 8'h00, m_rtc = 8'h00;

  // per-scenario statistics
  int         t, n_done, n_wr_low, n_rd_low, oe_data, contention, low_run, rise_t;
  int         done_q[$];
  int         gap_q[$];
  logic [7:0] a_byte, d_byte;
  bit         prev_busy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic clr();
    t = 0; n_done = 0; n_wr_low = 0; n_rd_low = 0; oe_data = 0; contention = 0;
    low_run = 0; rise_t = -1; a_byte = 8'hxx; d_byte = 8'hxx;
    done_q.delete(); gap_q.delete();
  endtask

  task automatic compare();
    bit in_a, in_d, a_stb, d_stb, e_busy, e_done;
    e_busy = act && (p <= BL);
    e_done = act && (p == BL + 1);
    in_a   = act && (p >= 1) && (p <= A_HLD);
    in_d   = act && (p > G1) && (p <= BL);
    a_stb  = act && (p >= A_STB0) && (p <= A_STB1);
    d_stb  = act && (p >= D_STB0) && (p <= D_STB1);
    chk("busy",     bus.busy,     e_busy);
    chk("done",     bus.done,     e_done);
    chk("cs_n",     bus.cs_n,     !(in_a || in_d));
    chk("a_d",      bus.a_d,      !in_a);
    chk("wr_n",     bus.wr_n,     !(a_stb || (d_stb && !m_rd)));
    chk("rd_n",     bus.rd_n,     !(d_stb && m_rd));
    chk("ad_oe",    bus.ad_oe,    in_a || (in_d && !m_rd));
    chk("ad_out",   bus.ad_out,   m_ad_out);
    chk("dato_rtc", bus.dato_rtc, m_rtc);
  endtask

  task automatic tick();
    logic s, rw;
    logic [7:0] ad, dt, ai;
    bit idle_prev;
    s = bus.start; rw = bus.RD_WR; ad = bus.dir_out; dt = bus.dato; ai = bus.ad_in;
    @(posedge clk);
    if (!reset) begin
      idle_prev = !act || (p > BL);
      if (act && (p == D_STB1) && m_rd) m_rtc = ai;
      if (idle_prev && s) begin
        act = 1'b1; p = 1; m_rd = rw; m_addr = ad; m_data = dt; m_ad_out = m_addr;
      end else if (act) begin
        p++;
        if ((p == G1 + 1) && !m_rd) m_ad_out = m_data;
        if (p > BL + 1) act = 1'b0;
      end
    end
    #1;
    compare();
    t++;
    if (bus.ad_oe && !bus.rd_n) contention++;
    if (!bus.wr_n) begin
      n_wr_low++;
      if (!bus.a_d) a_byte = bus.ad_out; else d_byte = bus.ad_out;
    end
    if (!bus.rd_n) n_rd_low++;
    if (bus.a_d && !bus.cs_n && bus.ad_oe && m_rd) oe_data++;
    if (bus.done) begin n_done++; done_q.push_back(t); end
    if (bus.busy && !prev_busy) begin
      if (rise_t < 0) rise_t = t;
      if (low_run > 0) gap_q.push_back(low_run);
      low_run = 0;
    end
    if (!bus.busy) low_run++;
    prev_busy = bus.busy;
  endtask

  task automatic issue(input logic rw, input logic [7:0] addr, input logic [7:0] data);
    bus.RD_WR = rw; bus.dir_out = addr; bus.dato = data; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.RD_WR = 1'b0; bus.dir_out = 8'h00; bus.dato = 8'h00;
    clr();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_dato_rtc", bus.dato_rtc, 8'h00);
    chk("rst_ad_out",   bus.ad_out,   8'h00);
    chk("rst_cs_n",     bus.cs_n,     1'b1);

    // write 0x45 to register 0x21
    clr();
    issue(1'b0, 8'h21, 8'h45);
    repeat (BL + 2) tick();
    chk("wr_addr_byte", a_byte, 8'h21);
    chk("wr_data_byte", d_byte, 8'h45);
    chk("wr_wr_low",    n_wr_low, 20);
    chk("wr_done_cnt",  n_done, 1);
    chk("wr_done_lag",  (done_q.size() > 0) ? done_q[0] - rise_t : -1, 31);
    chk("wr_dato_rtc",  bus.dato_rtc, 8'h00);

    // read register 0x22, chip returns 0x59
    clr();
    rd_byte = 8'h59;
    issue(1'b1, 8'h22, 8'h00);
    repeat (BL + 2) tick();
    chk("rd_dato_rtc", bus.dato_rtc, 8'h59);
    chk("rd_rd_low",   n_rd_low, 10);
    chk("rd_wr_low",   n_wr_low, 10);
    chk("rd_oe_data",  oe_data, 0);
    chk("rd_addr",     a_byte, 8'h22);

    // start pulsed at cycle 10 of an active write is ignored
    clr();
    issue(1'b0, 8'h10, 8'hAA);
    repeat (8) tick();
    bus.dir_out = 8'h33; bus.dato = 8'h99; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (BL + 4) tick();
    chk("busy_start_done", n_done, 1);
    chk("busy_start_addr", a_byte, 8'h10);
    chk("busy_start_data", d_byte, 8'hAA);

    // start held high for 70 cycles
    clr();
    bus.RD_WR = 1'b0; bus.dir_out = 8'h44; bus.dato = 8'h55; bus.start = 1'b1;
    repeat (70) tick();
    bus.start = 1'b0;
    chk("held_done_cnt", n_done, 2);
    chk("held_done1", (done_q.size() > 0) ? done_q[0] : 0, 32);
    chk("held_done2", (done_q.size() > 1) ? done_q[1] : 0, 64);
    chk("held_gap",   (gap_q.size() > 0) ? gap_q[0] : 99, 1);
    repeat (BL + 2) tick();

    // reset during the data strobe of a read
    clr();
    rd_byte = 8'h77;
    issue(1'b1, 8'h30, 8'h00);
    repeat (D_STB0 + 2) tick();
    chk("pre_rst_rd_n", bus.rd_n, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_rd_n",  bus.rd_n,  1'b1);
    chk("arst_cs_n",  bus.cs_n,  1'b1);
    chk("arst_ad_oe", bus.ad_oe, 1'b0);
    chk("arst_busy",  bus.busy,  1'b0);
    act = 1'b0; m_ad_out = 8'h00; m_rtc = 8'h00;
    repeat (2) tick();
    reset = 1'b0;
    repeat (BL) tick();
    chk("arst_no_done",  n_done, 0);
    chk("arst_dato_rtc", bus.dato_rtc, 8'h00);

    clr();
    rd_byte = 8'h12;
    issue(1'b1, 8'h31, 8'h00);
    repeat (BL + 2) tick();
    chk("post_rst_read", bus.dato_rtc, 8'h12);

    // random mix of reads and writes
    clr();
    for (int i = 0; i < 8; i++) begin
      rd_byte = 8'($urandom_range(0, 255));
      issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      repeat (BL + $urandom_range(0, 3)) tick();
    end
    repeat (4) tick();
    chk("rand_contention", contention, 0);
    chk("rand_done_cnt",   n_done, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rtc_bus_driver.md
# rtc_bus_driver

Physical-bus stage placed directly downstream of the RTC control state machine. It turns one register request (address `dir_out`, write data `dato`, direction `RD_WR`) into the multiplexed address/data strobe sequence of the parallel RTC chip. For reads it returns the captured byte as `dato_rtc`. All chip-side outputs are registered, so strobes are glitch-free. The top level owns the tristate pad and joins it using `ad_out`, `ad_oe` and `ad_in`.

## Interface
- `T_SETUP`, default 2: cycles that address/data are valid with CS low before the strobe falls (≥1).
- `T_PULSE`, default 10: cycles each RD/WR strobe stays low (≥2).
- `T_GAP`, default 5: cycles with CS high between the address phase and the data phase (≥1).

- `clk`  in  1  system clock (100 MHz).
- `reset`  in  1  asynchronous reset, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `RD_WR`  in  1  1 = read, 0 = write; latched with `start`.
- `dir_out`  in  8  RTC register address; latched with `start`.
- `dato`  in  8  write data; latched with `start`.
- `dato_rtc`  out  8  last byte read from the chip.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle completion pulse.
- `cs_n`, `rd_n`, `wr_n`  out  1 each  chip select, read strobe and write strobe, all active-low.
- `a_d`  out  1  0 = address phase, 1 = data phase.
- `ad_out`  out  8  byte driven onto the AD bus.
- `ad_oe`  out  1  AD pad output enable.
- `ad_in`  in  8  AD bus read-back.

## Operation
- States, in order: IDLE, A_SETUP, A_STRB, A_HOLD, GAP, D_SETUP, D_STRB, D_HOLD, then back to IDLE.
- A single down-counter times A_SETUP, A_STRB, GAP, D_SETUP and D_STRB. A_HOLD and D_HOLD last exactly 1 cycle.
- **IDLE:** `cs_n`=`rd_n`=`wr_n`=`a_d`=1, `ad_oe`=0, `busy`=0. On `start`=1, latch `RD_WR`, `dir_out` and `dato`, then enter A_SETUP.
- **A_SETUP / A_STRB / A_HOLD:**
  - `cs_n`=0, `a_d`=0, `ad_oe`=1, `ad_out`=latched address.
  - `wr_n`=0 only during A_STRB.
  - The address phase always uses WR, for both reads and writes.
- **GAP:** `cs_n`=1, `a_d`=1, `ad_oe`=0, all strobes high.
- **D_SETUP / D_STRB / D_HOLD:** `cs_n`=0, `a_d`=1.
  - Write: `ad_oe`=1, `ad_out`=latched data, `wr_n`=0 only during D_STRB.
  - Read: `ad_oe`=0 throughout, `rd_n`=0 only during D_STRB. `ad_in` is registered into `dato_rtc` on the clock edge that ends the last D_STRB cycle.
- **Leaving D_HOLD:** go to IDLE, pulse `done` for 1 cycle, deassert `busy`.
- `ad_oe` and `rd_n`=0 are never both asserted. Violating this is a design error.
- `dato_rtc` changes only on read captures. It holds its value across writes.
- `ad_out` holds its last value while `ad_oe`=0.

## Timing
- **Reset values:** `cs_n`=`rd_n`=`wr_n`=`a_d`=1, `ad_oe`=0, `ad_out`=0x00, `dato_rtc`=0x00, `busy`=0, `done`=0.
- **Start:** `start` is sampled at edge k. `busy`, `cs_n`=0 and `ad_oe`=1 all appear after edge k (cycle k+1).
- **Busy length:** 2·T_SETUP + 2·T_PULSE + T_GAP + 2 cycles; 31 cycles at the defaults.
- **Done:** `done`=1 in the first IDLE cycle, i.e. cycle 32 after acceptance at the defaults.
- **Strobe edges:** each strobe is low for exactly T_PULSE cycles. `cs_n` and `a_d` are stable for the whole time a strobe is low.
- **Start while busy:** ignored; nothing is latched.
- **Start held high:** a new transaction is accepted in the same cycle that `done`=1. `busy` then returns to 1 on the next cycle, so there is a one-cycle idle gap.
- **Reset mid-transaction:** all outputs go to their reset values immediately (asynchronously) and the FSM returns to IDLE. No `done` is produced.
- **Input changes:** changes to `dir_out`, `dato` or `RD_WR` after acceptance have no effect on the transaction in progress.

## Test plan
- **Write:** `start` with `RD_WR`=0, `dir_out`=0x21, `dato`=0x45.
  - Address phase: `ad_out`=0x21 with `wr_n` low for 10 cycles.
  - Data phase: `ad_out`=0x45 with `wr_n` low for 10 cycles.
  - `done` 31 cycles after `busy` rises; `dato_rtc` stays 0x00.
- **Read:** `RD_WR`=1, `dir_out`=0x22, bus model drives `ad_in`=0x59 while `rd_n`=0.
  - `dato_rtc`=0x59 from D_HOLD onward.
  - `ad_oe`=0 during the whole data phase.
  - `wr_n` low only during the address phase.
- **Start while busy:** pulse `start` (`dir_out`=0x33) at cycle 10 of an active write.
  - No second transaction and no change in sequence.
  - Exactly one `done`.
- **Start held high** for 70 cycles with `RD_WR`=0.
  - Two complete transactions, with `done` at cycle 32 and cycle 64.
  - `busy` low for exactly 1 cycle between them.
- **Reset mid-transaction:** assert `reset` during D_STRB of a read.
  - `rd_n`, `cs_n` go to 1 and `ad_oe` to 0 before the next clock edge.
  - `dato_rtc`=0x00, no `done`.
  - The next read (`ad_in`=0x12) completes normally with `dato_rtc`=0x12.
- **Bus-contention check** across random reads and writes: `ad_oe`=1 && `rd_n`=0 never occurs, and `cs_n`=1 throughout every GAP.
